wb_arbiter_rr2: RTL and testbench

Two-master, one-slave Wishbone B3 classic arbiter for the picorv32 Wishbone SoC, clocked from the clkgen `wb_clk`/`wb_rst` pair. It shares the SoC system bus between the CPU (master 0) and a second master (UART debug loader or DMA, master 1). Grant is round-robin and held for a whole `cyc` cycle. A per-transfer watchdog terminates hung transfers with `err`.

---
 rtl/wb_arb_pkg.sv | 25 ++
 rtl/wb_timeout_cnt.sv | 50 +++++
 rtl/wb_arbiter_rr2.sv | 184 ++++++++++++++++++
 tb/tb_wb_arbiter_rr2.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_arb_pkg.sv
// Shared types and helpers for the two-master Wishbone arbiter and its
// watchdog counter.
package wb_arb_pkg;

  // Arbiter state encoding (kept as plain constants for legacy tools).
  typedef logic [1:0] arb_state_t;
  localparam arb_state_t ST_IDLE = 2'd0;
  localparam arb_state_t ST_OWN0 = 2'd1;
  localparam arb_state_t ST_OWN1 = 2'd2;

  // Index of a bus master.
  typedef logic owner_t;
  localparam owner_t OWNER_M0 = 1'b0;
  localparam owner_t OWNER_M1 = 1'b1;

  // Width of a counter that must reach the value n (at least one bit).
  function automatic int cnt_width(input int unsigned n);
    if (n == 0) begin
      return 1;
    end else begin
      return $clog2(n + 1);
    end
  endfunction

endpackage

// File: rtl/wb_timeout_cnt.sv
// Wait-state watchdog: counts consecutive stalled cycles and flags expiry
// when the count reaches TIMEOUT_CYCLES. TIMEOUT_CYCLES = 0 disables it.
module wb_timeout_cnt
  import wb_arb_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic run,
  input  logic clr,
  output logic expire
);

  localparam int  CW      = cnt_width(TIMEOUT_CYCLES);
  localparam logic ENABLED = (TIMEOUT_CYCLES != 0);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;
  logic          hit_s;
  logic          run_s;

  assign run_s  = run & ENABLED;
  assign hit_s  = (cnt_q == CW'(TIMEOUT_CYCLES));
  assign expire = run_s & ~clr & hit_s;

  // Next count: clear wins, expiry restarts, otherwise count stalled cycles.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (expire) begin
      cnt_d = '0;
    end else if (run_s) begin
      cnt_d = cnt_q + CW'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Counter register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/wb_arbiter_rr2.sv
// Two-master, one-slave Wishbone B3 classic arbiter. Round-robin grant taken
// only in IDLE and held for the owner's whole cyc; slave handshakes pass
// through combinationally; a watchdog ends hung transfers with err.
module wb_arbiter_rr2
  import wb_arb_pkg::*;
#(
  parameter int unsigned AW             = 32,
  parameter int unsigned DW             = 32,
  parameter int unsigned TIMEOUT_CYCLES = 255,
  localparam int unsigned SW            = DW / 8
) (
  input  logic          wb_clk_i,
  input  logic          wb_rst_i,
  input  logic          m0_cyc_i,
  input  logic          m0_stb_i,
  input  logic          m0_we_i,
  input  logic [AW-1:0] m0_adr_i,
  input  logic [SW-1:0] m0_sel_i,
  input  logic [DW-1:0] m0_dat_i,
  output logic [DW-1:0] m0_dat_o,
  output logic          m0_ack_o,
  output logic          m0_err_o,
  output logic          m0_rty_o,
  input  logic          m1_cyc_i,
  input  logic          m1_stb_i,
  input  logic          m1_we_i,
  input  logic [AW-1:0] m1_adr_i,
  input  logic [SW-1:0] m1_sel_i,
  input  logic [DW-1:0] m1_dat_i,
  output logic [DW-1:0] m1_dat_o,
  output logic          m1_ack_o,
  output logic          m1_err_o,
  output logic          m1_rty_o,
  output logic          s_cyc_o,
  output logic          s_stb_o,
  output logic          s_we_o,
  output logic [AW-1:0] s_adr_o,
  output logic [SW-1:0] s_sel_o,
  output logic [DW-1:0] s_dat_o,
  input  logic [DW-1:0] s_dat_i,
  input  logic          s_ack_i,
  input  logic          s_err_i,
  input  logic          s_rty_i,
  output logic [1:0]    grant_o,
  output logic          timeout_o
);

  arb_state_t    state_q, state_d;
  owner_t        last_owner_q, last_owner_d;

  logic          own0_s, own1_s, owned_s;
  logic          sel_cyc_s, sel_stb_s, sel_we_s;
  logic [AW-1:0] sel_adr_s;
  logic [SW-1:0] sel_sel_s;
  logic [DW-1:0] sel_dat_s;
  logic          stb_raw_s, term_s;
  logic          wd_run_s, wd_clr_s, wd_expire_s, timeout_s;

  assign own0_s  = (state_q == ST_OWN0);
  assign own1_s  = (state_q == ST_OWN1);
  assign owned_s = own0_s | own1_s;

  // Arbitration in IDLE; release when the owner drops cyc.
  always_comb begin
    state_d      = state_q;
    last_owner_d = last_owner_q;
    case (state_q)
      ST_IDLE: begin
        if (m0_cyc_i && m1_cyc_i) begin
          if (last_owner_q == OWNER_M1) begin
            state_d      = ST_OWN0;
            last_owner_d = OWNER_M0;
          end else begin
            state_d      = ST_OWN1;
            last_owner_d = OWNER_M1;
          end
        end else if (m0_cyc_i) begin
          state_d      = ST_OWN0;
          last_owner_d = OWNER_M0;
        end else if (m1_cyc_i) begin
          state_d      = ST_OWN1;
          last_owner_d = OWNER_M1;
        end else begin
          state_d      = ST_IDLE;
        end
      end
      ST_OWN0: begin
        if (!m0_cyc_i) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_OWN0;
        end
      end
      ST_OWN1: begin
        if (!m1_cyc_i) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_OWN1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and round-robin history; master 0 wins the first tie after reset.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_q      <= ST_IDLE;
      last_owner_q <= OWNER_M1;
    end else begin
      state_q      <= state_d;
      last_owner_q <= last_owner_d;
    end
  end

  // Select the owner's request signals; everything is zero when idle.
  always_comb begin
    sel_cyc_s = 1'b0;
    sel_stb_s = 1'b0;
    sel_we_s  = 1'b0;
    sel_adr_s = '0;
    sel_sel_s = '0;
    sel_dat_s = '0;
    if (own0_s) begin
      sel_cyc_s = m0_cyc_i;
      sel_stb_s = m0_stb_i;
      sel_we_s  = m0_we_i;
      sel_adr_s = m0_adr_i;
      sel_sel_s = m0_sel_i;
      sel_dat_s = m0_dat_i;
    end else if (own1_s) begin
      sel_cyc_s = m1_cyc_i;
      sel_stb_s = m1_stb_i;
      sel_we_s  = m1_we_i;
      sel_adr_s = m1_adr_i;
      sel_sel_s = m1_sel_i;
      sel_dat_s = m1_dat_i;
    end else begin
      sel_cyc_s = 1'b0;
    end
  end

  assign stb_raw_s = sel_cyc_s & sel_stb_s;
  assign term_s    = s_ack_i | s_err_i | s_rty_i;

  // Watchdog counts owner strobe cycles without a termination.
  assign wd_run_s = owned_s & stb_raw_s & ~term_s;
  assign wd_clr_s = ~owned_s | ~stb_raw_s | term_s;

  wb_timeout_cnt #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk   (wb_clk_i),
    .rst   (wb_rst_i),
    .run   (wd_run_s),
    .clr   (wd_clr_s),
    .expire(wd_expire_s)
  );

  // A real slave termination in the expiry cycle always takes precedence.
  assign timeout_s = wd_expire_s & ~term_s;

  assign s_cyc_o   = sel_cyc_s;
  assign s_stb_o   = stb_raw_s & ~timeout_s;
  assign s_we_o    = sel_we_s;
  assign s_adr_o   = sel_adr_s;
  assign s_sel_o   = sel_sel_s;
  assign s_dat_o   = sel_dat_s;

  assign m0_dat_o  = s_dat_i;
  assign m1_dat_o  = s_dat_i;
  assign m0_ack_o  = own0_s & s_ack_i;
  assign m0_err_o  = own0_s & (s_err_i | timeout_s);
  assign m0_rty_o  = own0_s & s_rty_i;
  assign m1_ack_o  = own1_s & s_ack_i;
  assign m1_err_o  = own1_s & (s_err_i | timeout_s);
  assign m1_rty_o  = own1_s & s_rty_i;

  assign grant_o   = {own1_s, own0_s};
  assign timeout_o = timeout_s;

endmodule

// File: tb/tb_wb_arbiter_rr2.sv
// Self-checking bench for wb_arbiter_rr2: directed scenarios plus a random
// phase, every cycle compared against a behavioural bus-sharing model.
module tb_wb_arbiter_rr2;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int SW = DW / 8;
  localparam int TO = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          m0_cyc, m0_stb, m0_we, m1_cyc, m1_stb, m1_we;
  logic [AW-1:0] m0_adr, m1_adr;
  logic [SW-1:0] m0_sel, m1_sel;
  logic [DW-1:0] m0_dat, m1_dat;
  logic [DW-1:0] m0_dat_o, m1_dat_o;
  logic          m0_ack_o, m0_err_o, m0_rty_o, m1_ack_o, m1_err_o, m1_rty_o;
  logic          s_cyc_o, s_stb_o, s_we_o;
  logic [AW-1:0] s_adr_o;
  logic [SW-1:0] s_sel_o;
  logic [DW-1:0] s_dat_o;
  logic [DW-1:0] s_dat;
  logic          s_ack, s_err, s_rty;
  logic [1:0]    grant_o;
  logic          timeout_o;

  always #5 clk = ~clk;

  wb_arbiter_rr2 #(.AW(AW), .DW(DW), .TIMEOUT_CYCLES(TO)) dut (
    .wb_clk_i(clk), .wb_rst_i(rst),
    .m0_cyc_i(m0_cyc), .m0_stb_i(m0_stb), .m0_we_i(m0_we), .m0_adr_i(m0_adr),
    .m0_sel_i(m0_sel), .m0_dat_i(m0_dat), .m0_dat_o(m0_dat_o),
    .m0_ack_o(m0_ack_o), .m0_err_o(m0_err_o), .m0_rty_o(m0_rty_o),
    .m1_cyc_i(m1_cyc), .m1_stb_i(m1_stb), .m1_we_i(m1_we), .m1_adr_i(m1_adr),
    .m1_sel_i(m1_sel), .m1_dat_i(m1_dat), .m1_dat_o(m1_dat_o),
    .m1_ack_o(m1_ack_o), .m1_err_o(m1_err_o), .m1_rty_o(m1_rty_o),
    .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_we_o(s_we_o), .s_adr_o(s_adr_o),
    .s_sel_o(s_sel_o), .s_dat_o(s_dat_o), .s_dat_i(s_dat),
    .s_ack_i(s_ack), .s_err_i(s_err), .s_rty_i(s_rty),
    .grant_o(grant_o), .timeout_o(timeout_o)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Model: who owns the bus (-1 none), who owned it last, and how many
  // consecutive stalled strobe cycles the owner has seen so far.
  int mdl_owner;
  int mdl_last;
  int mdl_stall_run;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    mdl_owner     = -1;
    mdl_last      = 1;
    mdl_stall_run = 0;
  endtask

  task automatic zero_inputs();
    m0_cyc = 1'b0; m0_stb = 1'b0; m0_we = 1'b0; m0_adr = '0; m0_sel = '0; m0_dat = '0;
    m1_cyc = 1'b0; m1_stb = 1'b0; m1_we = 1'b0; m1_adr = '0; m1_sel = '0; m1_dat = '0;
    s_dat = '0; s_ack = 1'b0; s_err = 1'b0; s_rty = 1'b0;
  endtask

  // One bus cycle: compare all outputs mid-cycle, then advance the model
  // across the rising edge. Returns at posedge + 1.
  task automatic do_cycle();
    logic          cyc, stb, we, term, stall, fire;
    logic [AW-1:0] adr;
    logic [SW-1:0] sel;
    logic [DW-1:0] dat;
    logic [1:0]    exp_grant;
    int            nxt_owner;
    @(negedge clk);
    cyc = 1'b0; stb = 1'b0; we = 1'b0; adr = '0; sel = '0; dat = '0;
    exp_grant = 2'b00;
    if (mdl_owner == 0) begin
      cyc = m0_cyc; stb = m0_stb; we = m0_we; adr = m0_adr; sel = m0_sel; dat = m0_dat;
      exp_grant = 2'b01;
    end else if (mdl_owner == 1) begin
      cyc = m1_cyc; stb = m1_stb; we = m1_we; adr = m1_adr; sel = m1_sel; dat = m1_dat;
      exp_grant = 2'b10;
    end
    term  = s_ack | s_err | s_rty;
    stall = cyc & stb & ~term;
    // Expiry lands on every (TO+1)-th consecutive stalled strobe cycle.
    fire  = stall && (((mdl_stall_run + 1) % (TO + 1)) == 0);
    check_val("grant", grant_o, exp_grant);
    check_val("s_cyc", s_cyc_o, cyc);
    check_val("s_stb", s_stb_o, cyc & stb & ~fire);
    check_val("s_we", s_we_o, we);
    check_val("s_adr", s_adr_o, adr);
    check_val("s_sel", s_sel_o, sel);
    check_val("s_dat", s_dat_o, dat);
    check_val("m0_dat", m0_dat_o, s_dat);
    check_val("m1_dat", m1_dat_o, s_dat);
    check_val("m0_term", {m0_ack_o, m0_err_o, m0_rty_o},
              (mdl_owner == 0) ? {s_ack, s_err | fire, s_rty} : 3'b000);
    check_val("m1_term", {m1_ack_o, m1_err_o, m1_rty_o},
              (mdl_owner == 1) ? {s_ack, s_err | fire, s_rty} : 3'b000);
    check_val("timeout", timeout_o, fire);
    nxt_owner = mdl_owner;
    if (mdl_owner < 0) begin
      if (m0_cyc && m1_cyc) nxt_owner = 1 - mdl_last;
      else if (m0_cyc)      nxt_owner = 0;
      else if (m1_cyc)      nxt_owner = 1;
      if (nxt_owner >= 0) mdl_last = nxt_owner;
    end else if (!cyc) begin
      nxt_owner = -1;
    end
    mdl_stall_run = stall ? mdl_stall_run + 1 : 0;
    @(posedge clk);
    mdl_owner = nxt_owner;
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    zero_inputs();
    @(posedge clk);
    @(posedge clk);
    #1;
    check_val("rst_grant", grant_o, 2'b00);
    check_val("rst_s_cyc", s_cyc_o, 1'b0);
    check_val("rst_s_stb", s_stb_o, 1'b0);
    check_val("rst_timeout", timeout_o, 1'b0);
    check_val("rst_terms", {m0_ack_o, m0_err_o, m0_rty_o, m1_ack_o, m1_err_o, m1_rty_o}, 6'b0);
    rst = 1'b0;
    model_reset();
  endtask

  int b0, b1;

  initial begin
    model_reset();
    do_reset();

    // Single m0 read, slave acks after two wait states.
    m0_cyc = 1'b1; m0_stb = 1'b1; m0_we = 1'b0; m0_adr = 32'h0000_1000; m0_sel = 4'hF;
    do_cycle();
    check_val("rd_grant", grant_o, 2'b01);
    do_cycle();
    do_cycle();
    s_ack = 1'b1; s_dat = 32'hDEAD_BEEF; #1;
    check_val("rd_m0_ack", m0_ack_o, 1'b1);
    check_val("rd_m0_dat", m0_dat_o, 32'hDEAD_BEEF);
    check_val("rd_m1_ack", m1_ack_o, 1'b0);
    do_cycle();
    s_ack = 1'b0; m0_cyc = 1'b0; m0_stb = 1'b0;
    do_cycle();
    check_val("rd_release", grant_o, 2'b00);

    // Simultaneous requests from reset, alternation, and no starvation.
    do_reset();
    m0_cyc = 1'b1; m1_cyc = 1'b1;
    do_cycle();
    check_val("tie1_grant", grant_o, 2'b01);
    do_cycle();
    m0_cyc = 1'b0;
    do_cycle();
    check_val("tie1_dead", grant_o, 2'b00);
    do_cycle();
    check_val("tie1_m1", grant_o, 2'b10);
    m1_cyc = 1'b0;
    do_cycle();
    m0_cyc = 1'b1; m1_cyc = 1'b1;
    do_cycle();
    check_val("tie2_grant", grant_o, 2'b01);
    m0_cyc = 1'b0;
    do_cycle();
    m0_cyc = 1'b1;
    do_cycle();
    check_val("nostarve", grant_o, 2'b10);
    m0_cyc = 1'b0; m1_cyc = 1'b0;
    do_cycle();
    do_cycle();

    // Watchdog: slave never answers, then an ack exactly on expiry.
    do_reset();
    m0_cyc = 1'b1; m0_stb = 1'b1; m0_adr = 32'h0000_2000;
    do_cycle();
    for (int i = 0; i < TO; i++) do_cycle();
    check_val("to_err", m0_err_o, 1'b1);
    check_val("to_pulse", timeout_o, 1'b1);
    check_val("to_stb_mask", s_stb_o, 1'b0);
    do_cycle();
    check_val("to_hold", grant_o, 2'b01);
    for (int i = 0; i < TO; i++) do_cycle();
    s_ack = 1'b1; #1;
    check_val("tack_ack", m0_ack_o, 1'b1);
    check_val("tack_err", m0_err_o, 1'b0);
    check_val("tack_to", timeout_o, 1'b0);
    do_cycle();
    s_ack = 1'b0; m0_cyc = 1'b0; m0_stb = 1'b0;
    do_cycle();

    // Async reset during a stalled m1 write.
    m1_cyc = 1'b1; m1_stb = 1'b1; m1_we = 1'b1; m1_adr = 32'h0000_3000; m1_dat = 32'h1234_5678;
    do_cycle();
    check_val("ar_grant", grant_o, 2'b10);
    do_cycle();
    #2; rst = 1'b1; #1;
    check_val("ar_s_cyc", s_cyc_o, 1'b0);
    check_val("ar_s_stb", s_stb_o, 1'b0);
    check_val("ar_grant0", grant_o, 2'b00);
    zero_inputs();
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
    m0_cyc = 1'b1; m1_cyc = 1'b1;
    do_cycle();
    check_val("ar_tie", grant_o, 2'b01);
    zero_inputs();
    do_cycle();

    // Random traffic against the model.
    b0 = 0; b1 = 0;
    for (int c = 0; c < 2000; c++) begin
      if (b0 == 0 && m0_cyc) m0_cyc = 1'b0;
      else if (b0 == 0 && $urandom_range(0, 3) == 0) begin m0_cyc = 1'b1; b0 = $urandom_range(1, 14); end
      if (b1 == 0 && m1_cyc) m1_cyc = 1'b0;
      else if (b1 == 0 && $urandom_range(0, 3) == 0) begin m1_cyc = 1'b1; b1 = $urandom_range(1, 14); end
      if (b0 > 0) b0--;
      if (b1 > 0) b1--;
      m0_stb = ($urandom_range(0, 3) != 0); m1_stb = ($urandom_range(0, 3) != 0);
      m0_we = $urandom_range(0, 1); m1_we = $urandom_range(0, 1);
      m0_adr = $urandom; m1_adr = $urandom; m0_dat = $urandom; m1_dat = $urandom;
      m0_sel = $urandom_range(0, 15); m1_sel = $urandom_range(0, 15);
      s_dat = $urandom;
      s_ack = 1'b0; s_err = 1'b0; s_rty = 1'b0;
      // Alternate between a responsive slave and a silent one.
      if (((c / 40) % 2) == 0 && $urandom_range(0, 3) == 0) begin
        case ($urandom_range(0, 5))
          0:       s_err = 1'b1;
          1:       s_rty = 1'b1;
          default: s_ack = 1'b1;
        endcase
      end
      do_cycle();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
